usb_nrzi_tx: RTL and testbench

Parametrised USB low/full-speed transmit line encoder. It arbitrates between N_CH byte-stream packet sources (ACK, descriptor, data responders, ...) and frames each packet with SYNC. It serialises bytes LSB-first with bit stuffing and NRZI encoding, then appends a configurable EOP. It sits between the protocol responders and the D+/D- output buffers, and advances one bit per `checkData` strobe.

---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/usb_tx_arbiter.sv | 36 +++
 rtl/usb_nrzi_tx.sv | 212 +++++++++++++++++++++
 tb/tb_usb_nrzi_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and line encodings for the USB NRZI transmit path.
// Line values are packed as {NRZI, NRZI_not}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [1:0] LINE_SE0     = 2'b00;

  // Low speed idles with D- high, full speed with D+ high.
  function automatic logic [1:0] line_j(input logic low_speed);
    return low_speed ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] line_k(input logic low_speed);
    return ~line_j(low_speed);
  endfunction

endpackage

// File: rtl/usb_tx_arbiter.sv
// Fixed-priority channel arbiter: lowest-index requester wins, and the
// grant is held from lock until free so a packet keeps its source.
module usb_tx_arbiter #(
  parameter int N_CH = 2,
  parameter int CH_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            lock,
  input  logic            free,
  output logic            any,
  output logic [CH_W-1:0] pick,
  output logic [CH_W-1:0] grant
);

  assign any = |req;

  always_comb begin
    pick = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) pick = CH_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
    end else if (lock) begin
      grant <= pick;
    end else if (free) begin
      grant <= '0;
    end
  end

endmodule

// File: rtl/usb_nrzi_tx.sv
// USB low/full-speed transmit encoder: SYNC framing, LSB-first shifting,
// bit stuffing, NRZI and EOP, advancing one bit per checkData strobe.
//
// Handshake: a source holds src_valid/src_data/src_last; the byte is taken
// on the useClk edge where src_ready pulses (one cycle, granted channel only).
// There is no back-pressure: a missing byte at fetch time ends the packet.
module usb_nrzi_tx
  import usb_tx_pkg::*;
#(
  parameter  int N_CH         = 2,
  parameter  int LOW_SPEED    = 1,
  parameter  int STUFF_LEN    = 6,
  parameter  int EOP_SE0_BITS = 2,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W        = $clog2(STUFF_LEN + 1)
) (
  input  logic              useClk,
  input  logic              rst,
  input  logic              checkData,
  input  logic [N_CH-1:0]   src_valid,
  input  logic [8*N_CH-1:0] src_data,
  input  logic [N_CH-1:0]   src_last,
  output logic [N_CH-1:0]   src_ready,
  output logic              NRZI,
  output logic              NRZI_not,
  output logic              oe,
  output logic              busy,
  output logic [CH_W-1:0]   active_ch,
  output logic              underrun,
  output logic              pkt_done,
  output state_t            state
);

  localparam logic [1:0] LINE_J = line_j(LOW_SPEED != 0);
  localparam logic [1:0] LINE_K = line_k(LOW_SPEED != 0);

  state_t            state_q, state_d;
  logic [1:0]        line_q, line_d;
  logic              oe_q, oe_d, busy_q, busy_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_bit;
  logic [2:0]        se0_q, se0_d;
  logic [N_CH-1:0]   ready_q, ready_d;
  logic              underrun_q, underrun_d, pkt_done_q, pkt_done_d;
  logic              tx_bit, stuff_due, fetch, lock, free, any;
  logic [CH_W-1:0]   pick, grant;
  logic [7:0]        src_byte [N_CH];

  always_comb begin
    for (int c = 0; c < N_CH; c++) src_byte[c] = src_data[8*c +: 8];
  end

  usb_tx_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arbiter (
    .clk   (useClk),
    .rst   (rst),
    .req   (src_valid),
    .lock  (lock),
    .free  (free),
    .any   (any),
    .pick  (pick),
    .grant (grant)
  );

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    last_d     = last_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    se0_d      = se0_q;
    ready_d    = '0;
    underrun_d = 1'b0;
    pkt_done_d = 1'b0;
    lock       = 1'b0;
    free       = 1'b0;
    fetch      = 1'b0;
    tx_bit     = (state_q == ST_SYNC) ? SYNC_PATTERN[bit_q] : byte_q[bit_q];
    cnt_bit    = tx_bit ? cnt_q + CNT_W'(1) : '0;
    stuff_due  = (cnt_bit == CNT_W'(STUFF_LEN));

    if (checkData) begin
      case (state_q)
        ST_IDLE: begin
          line_d = LINE_J;
          oe_d   = 1'b0;
          busy_d = 1'b0;
          bit_d  = '0;
          cnt_d  = '0;
          se0_d  = '0;
          done_d = 1'b0;
          if (any) begin
            // SYNC bit 0 is a 0, so the first bit time is always K.
            lock           = 1'b1;
            ready_d[pick]  = 1'b1;
            byte_d         = src_byte[pick];
            last_d         = src_last[pick];
            line_d         = LINE_K;
            oe_d           = 1'b1;
            busy_d         = 1'b1;
            bit_d          = 3'd1;
            state_d        = ST_SYNC;
          end else begin
            free = 1'b1;
          end
        end
        ST_SYNC, ST_DATA: begin
          line_d = tx_bit ? line_q : ~line_q;
          cnt_d  = cnt_bit;
          bit_d  = bit_q + 3'd1;
          if (stuff_due) begin
            // A stuff after bit 7 defers the byte fetch to the stuff tick.
            state_d = ST_STUFF;
            done_d  = (bit_q == 3'd7) && (state_q == ST_DATA);
          end else if (bit_q == 3'd7) begin
            state_d = ST_DATA;
            fetch   = (state_q == ST_DATA);
          end
        end
        ST_STUFF: begin
          line_d = ~line_q;
          cnt_d  = '0;
          if (done_q) begin
            done_d = 1'b0;
            fetch  = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_EOP_SE0: begin
          line_d = LINE_SE0;
          if (se0_q == 3'(EOP_SE0_BITS - 1)) begin
            se0_d   = '0;
            state_d = ST_EOP_J;
          end else begin
            se0_d = se0_q + 3'd1;
          end
        end
        ST_EOP_J: begin
          line_d     = LINE_J;
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (fetch) begin
        if (last_q) begin
          state_d = ST_EOP_SE0;
        end else if (src_valid[grant]) begin
          ready_d[grant] = 1'b1;
          byte_d         = src_byte[grant];
          last_d         = src_last[grant];
          state_d        = ST_DATA;
        end else begin
          underrun_d = 1'b1;
          last_d     = 1'b1;
          state_d    = ST_EOP_SE0;
        end
      end
    end
  end

  always_ff @(posedge useClk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      line_q     <= LINE_J;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      bit_q      <= '0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      se0_q      <= '0;
      ready_q    <= '0;
      underrun_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      se0_q      <= se0_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign NRZI      = line_q[1];
  assign NRZI_not  = line_q[0];
  assign oe        = oe_q;
  assign busy      = busy_q;
  assign active_ch = grant;
  assign src_ready = ready_q;
  assign underrun  = underrun_q;
  assign pkt_done  = pkt_done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx: a low-speed and a full-speed instance
// share stimulus; per-tick line/pulse histories are compared to hand traces.
module tb_usb_nrzi_tx;
  import usb_tx_pkg::*;

  localparam int N_CH = 3;

  logic              useClk = 1'b0;
  logic              rst = 1'b1;
  logic              checkData = 1'b0;
  logic [N_CH-1:0]   src_valid = '0;
  logic [N_CH-1:0]   src_last = '0;
  logic [8*N_CH-1:0] src_data = '0;

  logic [N_CH-1:0] ls_ready, fs_ready;
  logic            ls_nrzi, ls_not, ls_oe, ls_busy, ls_under, ls_done;
  logic            fs_nrzi, fs_not, fs_oe, fs_busy, fs_under, fs_done;
  logic [1:0]      ls_ch, fs_ch;
  state_t          ls_state, fs_state;

  int checks = 0;
  int errors = 0;

  logic [8:0]      q0[$];
  logic [8:0]      q2[$];
  logic [N_CH-1:0] mask = '1;

  logic [63:0] cap_nrzi, cap_not, cap_ready, cap_ready2, cap_under, cap_done, cap_ch;

  usb_nrzi_tx #(.N_CH(N_CH), .LOW_SPEED(1), .STUFF_LEN(6), .EOP_SE0_BITS(2)) u_ls (
    .useClk(useClk), .rst(rst), .checkData(checkData),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(ls_ready), .NRZI(ls_nrzi), .NRZI_not(ls_not), .oe(ls_oe),
    .busy(ls_busy), .active_ch(ls_ch), .underrun(ls_under),
    .pkt_done(ls_done), .state(ls_state)
  );

  usb_nrzi_tx #(.N_CH(N_CH), .LOW_SPEED(0), .STUFF_LEN(6), .EOP_SE0_BITS(2)) u_fs (
    .useClk(useClk), .rst(rst), .checkData(checkData),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(fs_ready), .NRZI(fs_nrzi), .NRZI_not(fs_not), .oe(fs_oe),
    .busy(fs_busy), .active_ch(fs_ch), .underrun(fs_under),
    .pkt_done(fs_done), .state(fs_state)
  );

  // clock / reset
  always #5 useClk = ~useClk;

  task automatic pulse_reset();
    @(negedge useClk);
    rst = 1'b1;
    @(negedge useClk);
    rst = 1'b0;
  endtask

  // driver
  task automatic drive_src();
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    if (q0.size() > 0) begin
      src_valid[0]    = mask[0];
      src_data[7:0]   = q0[0][7:0];
      src_last[0]     = q0[0][8];
    end
    if (q2.size() > 0) begin
      src_valid[2]    = mask[2];
      src_data[23:16] = q2[0][7:0];
      src_last[2]     = q2[0][8];
    end
  endtask

  task automatic clear_cap();
    cap_nrzi = '0; cap_not = '0; cap_ready = '0; cap_ready2 = '0;
    cap_under = '0; cap_done = '0; cap_ch = '0;
  endtask

  // One checkData strobe with an idle clock before it; outputs are sampled
  // on the falling edge after the strobe's rising edge.
  task automatic tick();
    @(negedge useClk);
    drive_src();
    checkData = 1'b1;
    @(negedge useClk);
    checkData = 1'b0;
    cap_nrzi   = {cap_nrzi[62:0], ls_nrzi};
    cap_not    = {cap_not[62:0], ls_not};
    cap_ready  = {cap_ready[62:0], |ls_ready};
    cap_ready2 = {cap_ready2[62:0], ls_ready[2]};
    cap_under  = {cap_under[62:0], ls_under};
    cap_done   = {cap_done[62:0], ls_done};
    cap_ch     = {cap_ch[62:0], (ls_ch != 2'd0)};
    if (ls_ready[0] && q0.size() > 0) void'(q0.pop_front());
    if (ls_ready[2] && q2.size() > 0) void'(q2.pop_front());
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_cap();
    repeat (3) @(negedge useClk);
    rst = 1'b0;

    // reset state
    check("rst_ls_line", {ls_nrzi, ls_not}, 2'b01);
    check("rst_fs_line", {fs_nrzi, fs_not}, 2'b10);
    check("rst_ls_ctrl", {ls_oe, ls_busy, ls_under, ls_done}, 4'b0000);
    check("rst_ls_ready", ls_ready, 3'b000);
    check("rst_ls_ch", ls_ch, 2'd0);
    check("rst_ls_state", ls_state, ST_IDLE);

    // single byte 0x00 on ch0
    q0.push_back({1'b1, 8'h00});
    clear_cap();
    tick();
    check("t1_ready", ls_ready, 3'b001);
    check("t1_oe_busy", {ls_oe, ls_busy}, 2'b11);
    check("t1_ls_first", {ls_nrzi, ls_not}, 2'b10);
    check("t1_fs_first", {fs_nrzi, fs_not}, 2'b01);
    repeat (4) tick();
    repeat (3) @(negedge useClk);
    check("stall_line", ls_nrzi, 1'b1);
    check("stall_ready", ls_ready, 3'b000);
    repeat (14) tick();
    check("t1_nrzi", cap_nrzi, 19'b10101011_01010101_000);
    check("t1_not", cap_not, 19'b01010100_10101010_001);
    check("t1_done", cap_done, 19'b00000000_00000000_001);
    check("t1_ready_hist", cap_ready, 19'b10000000_00000000_000);
    tick();
    check("t1_idle", {ls_oe, ls_busy, ls_nrzi, ls_not}, 4'b0001);

    // 0xFF then 0x00: one stuff after the fifth data one
    q0.push_back({1'b0, 8'hFF});
    q0.push_back({1'b1, 8'h00});
    clear_cap();
    repeat (28) tick();
    check("t2_nrzi", cap_nrzi, 28'b10101011_111110000_10101010_000);
    check("t2_ready", cap_ready, 28'b10000000_000000001_00000000_000);
    check("t2_done", cap_done, 28'b00000000_000000000_00000000_001);
    check("t2_under", cap_under, 64'd0);
    tick();

    // final byte 0x3F: stuff after bit 4
    q0.push_back({1'b1, 8'h3F});
    clear_cap();
    repeat (20) tick();
    check("t3_nrzi", cap_nrzi, 20'b10101011_111110010_000);
    check("t3_done", cap_done, 20'b00000000_000000000_001);
    tick();

    // 0xFC then 0x00: stuff after bit 7, fetch on the stuff tick
    q0.push_back({1'b0, 8'hFC});
    q0.push_back({1'b1, 8'h00});
    clear_cap();
    repeat (28) tick();
    check("t4_nrzi", cap_nrzi, 28'b10101011_01111111_0_10101010_000);
    check("t4_ready", cap_ready, 28'b10000000_00000000_1_00000000_000);
    tick();

    // ch0 and ch2 request together
    q0.push_back({1'b1, 8'h00});
    q2.push_back({1'b1, 8'h00});
    clear_cap();
    repeat (19) tick();
    check("t5_ch2_ready_quiet", cap_ready2, 64'd0);
    check("t5_ch0_active", cap_ch, 64'd0);
    check("t5_ch0_done", cap_done, 19'b00000000_00000000_001);
    clear_cap();
    tick();
    check("t5_ch2_grant", ls_ready, 3'b100);
    check("t5_ch2_active", ls_ch, 2'd2);
    check("t5_ch2_line", {ls_oe, ls_nrzi}, 2'b11);
    repeat (18) tick();
    check("t5_ch2_nrzi", cap_nrzi, 19'b10101011_01010101_000);
    tick();

    // two-byte packet starved at the second fetch
    q0.push_back({1'b0, 8'h00});
    q0.push_back({1'b1, 8'h55});
    clear_cap();
    tick();
    mask[0] = 1'b0;
    repeat (18) tick();
    check("t6_under", cap_under, 19'b00000000_00000001_000);
    check("t6_ready", cap_ready, 19'b10000000_00000000_000);
    check("t6_nrzi", cap_nrzi, 19'b10101011_01010101_000);
    check("t6_done", cap_done, 19'b00000000_00000000_001);
    q0.delete();
    mask = '1;
    tick();

    // reset in the middle of DATA
    q0.push_back({1'b1, 8'h00});
    repeat (12) tick();
    check("t7_pre_state", ls_state, ST_DATA);
    pulse_reset();
    check("t7_ls_line", {ls_nrzi, ls_not}, 2'b01);
    check("t7_ls_ctrl", {ls_oe, ls_busy}, 2'b00);
    check("t7_fs_line", {fs_nrzi, fs_not}, 2'b10);
    check("t7_fs_oe", fs_oe, 1'b0);
    check("t7_state", ls_state, ST_IDLE);
    clear_cap();
    repeat (3) tick();
    check("t7_no_eop", {cap_nrzi[2:0], cap_not[2:0]}, 6'b000111);
    check("t7_no_done", cap_done, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
